// File: rtl/hrm_core_pkg.sv
// Shared constants and types for the 16-bit heart-rate-monitor core.
package hrm_core_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 8;

  // Encoding that stops instruction fetch until resumed.
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0001;

  // Opcode field lives in instruction bits [15:12].
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam logic [3:0] OPC_ADDSUB = 4'b1111;
  localparam logic [3:0] OPC_ADDI   = 4'b0101;
  localparam logic [3:0] OPC_SB     = 4'b0100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/iram_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the byte PC, reads the IRAM combinationally,
// holds one buffered instruction for decode, parks on HALT and accepts redirects.
module iram_fetch_ctrl
  import hrm_core_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_WORD = hrm_core_pkg::HALT_WORD
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic [ADDR_W-1:0]  ADDR,
  input  logic [INSTR_W-1:0] Q,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               resume,
  output logic               halted,
  output logic [15:0]        issue_count
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic [15:0]        cnt_q, cnt_d;

  logic buf_free;
  logic accept;

  assign buf_free = ~valid_q | instr_ready;
  assign accept   = valid_q & instr_ready;

  // Next-state: redirect beats fetch in RUN; HALT only listens to resume.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q + {15'd0, accept};

    unique case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          // Flush the buffer; an acceptance this cycle was already counted above.
          pc_d    = redirect_addr & 8'hFE;
          valid_d = 1'b0;
        end else if (buf_free) begin
          pc_d = pc_q + 8'd2;
          if (Q == HALT_WORD) begin
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else begin
            instr_d = Q;
            ipc_d   = pc_q;
            valid_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ADDR        = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_iram_fetch_ctrl.sv
// Self-checking bench for iram_fetch_ctrl: directed walk through the fetch,
// backpressure, redirect, wrap and halt behaviour, then randomized traffic,
// every cycle compared against a behavioural fetch model.
module tb_iram_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  ADDR;
  logic [15:0] Q;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_addr = 8'h00;
  logic        resume = 1'b0;
  logic        halted;
  logic [15:0] issue_count;

  logic [15:0] mem [128];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // Behavioural model state
  int          m_pc;
  bit          m_valid;
  bit          m_halted;
  logic [15:0] m_instr;
  int          m_ipc;
  int          m_cnt;
  int          acc_q[$];

  always #5 CLK = ~CLK;

  assign Q = mem[ADDR[7:1]];

  iram_fetch_ctrl #(.RESET_PC(8'h00), .HALT_WORD(16'h0001)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .Q(Q),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .resume(resume), .halted(halted),
    .issue_count(issue_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'h0001) w = 16'h8001;
    return w;
  endfunction

  // One clock: record acceptance, advance the model with the inputs seen at the edge,
  // then compare all outputs shortly after the edge.
  task automatic step();
    logic [15:0] w;
    if (instr_valid === 1'b1 && instr_ready) begin
      acc_q.push_back(int'(instr_pc));
      check("acc_word", instr, mem[instr_pc[7:1]]);
    end
    @(posedge CLK);
    if (RESET) begin
      m_pc = 0; m_valid = 0; m_halted = 0; m_instr = 16'h0; m_ipc = 0; m_cnt = 0;
    end else begin
      if (m_valid && instr_ready) m_cnt = (m_cnt + 1) % 65536;
      if (m_halted) begin
        if (resume) m_halted = 0;
      end else if (redirect_valid) begin
        m_pc = int'(redirect_addr) / 2 * 2;
        m_valid = 0;
      end else if (!m_valid || instr_ready) begin
        w = mem[m_pc / 2];
        if (w == 16'h0001) begin
          m_valid = 0;
          m_halted = 1;
        end else begin
          m_instr = w;
          m_ipc = m_pc;
          m_valid = 1;
        end
        m_pc = (m_pc + 2) % 256;
      end
    end
    #1;
    check("ADDR", ADDR, m_pc);
    check("instr_valid", instr_valid, m_valid);
    check("halted", halted, m_halted);
    check("issue_count", issue_count, m_cnt);
    check("instr", instr, m_instr);
    check("instr_pc", instr_pc, m_ipc);
    check("no_halt_issue", instr_valid && instr == 16'h0001, 0);
  endtask

  task automatic run_until_halt();
    for (int i = 0; i < 40; i++) begin
      if (halted) break;
      step();
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic run_until_ipc(input logic [7:0] pc);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid && instr_pc == pc) break;
      step();
    end
    check("ipc_reached", instr_valid && instr_pc == pc, 1);
  endtask

  task automatic redirect_to(input logic [7:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] snap;

    // Default program: HALT at 0x10 and 0x1C, word 0x0000 at 0xFE.
    for (int i = 0; i < 128; i++) mem[i] = rand_word();
    mem[8]   = 16'h0001;
    mem[14]  = 16'h0001;
    mem[127] = 16'h0000;

    // Reset and first fetch
    RESET = 1'b1;
    step(); step();
    check("rst_ADDR", ADDR, 8'h00);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_count", issue_count, 0);
    check("rst_instr", instr, 0);
    check("rst_ipc", instr_pc, 0);
    RESET = 1'b0;
    instr_ready = 1'b1;
    acc_q.delete();
    step();
    check("first_valid", instr_valid, 1);
    check("first_ipc", instr_pc, 8'h00);

    // Run to the first HALT
    run_until_halt();
    check("h1_ADDR", ADDR, 8'h12);
    check("h1_count", issue_count, 8);
    check("h1_n", acc_q.size(), 8);
    for (int i = 0; i < 8 && i < acc_q.size(); i++) check("h1_pc", acc_q[i], 2 * i);

    // Resume to the second HALT
    acc_q.delete();
    resume = 1'b1; step(); resume = 1'b0;
    run_until_halt();
    check("h2_ADDR", ADDR, 8'h1E);
    check("h2_count", issue_count, 13);
    check("h2_n", acc_q.size(), 5);
    for (int i = 0; i < 5 && i < acc_q.size(); i++) check("h2_pc", acc_q[i], 8'h12 + 2 * i);

    // Backpressure while 0x04 is buffered
    resume = 1'b1; step(); resume = 1'b0;
    redirect_to(8'h00);
    run_until_ipc(8'h04);
    snap = issue_count;
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ipc", instr_pc, 8'h04);
      check("bp_ADDR", ADDR, 8'h06);
      check("bp_instr", instr, mem[2]);
      check("bp_count", issue_count, snap);
    end
    acc_q.delete();
    instr_ready = 1'b1;
    step(); step();
    check("bp_n", acc_q.size() >= 2, 1);
    if (acc_q.size() >= 2) begin
      check("bp_acc0", acc_q[0], 8'h04);
      check("bp_acc1", acc_q[1], 8'h06);
    end

    // Redirect while 0x02 is accepted
    redirect_to(8'h00);
    run_until_ipc(8'h02);
    snap = issue_count;
    redirect_to(8'h25);
    check("rd_ADDR", ADDR, 8'h24);
    check("rd_valid", instr_valid, 0);
    check("rd_count", issue_count, snap + 16'd1);
    step();
    check("rd_ipc", instr_pc, 8'h24);
    check("rd_valid2", instr_valid, 1);

    // Wrap from 0xFE to 0x00
    redirect_to(8'hFE);
    acc_q.delete();
    step();
    check("wrap_ipc", instr_pc, 8'hFE);
    check("wrap_word", instr, 16'h0000);
    step(); step(); step();
    check("wrap_n", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("wrap_acc0", acc_q[0], 8'hFE);
      check("wrap_acc1", acc_q[1], 8'h00);
      check("wrap_acc2", acc_q[2], 8'h02);
    end

    // Reset together with a redirect
    RESET = 1'b1;
    redirect_to(8'h80);
    check("rr_ADDR", ADDR, 8'h00);
    check("rr_valid", instr_valid, 0);
    check("rr_count", issue_count, 0);
    RESET = 1'b0;

    // Redirect during HALT is ignored
    run_until_halt();
    redirect_to(8'h40);
    check("hr_halted", halted, 1);
    check("hr_ADDR", ADDR, 8'h12);

    // Randomized traffic over a random program
    RESET = 1'b1;
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 16'h0001 : rand_word();
    step();
    RESET = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = 8'($urandom);
      resume         = ($urandom_range(0, 9) == 0);
      RESET          = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iram_fetch_ctrl.md
# iram_fetch_ctrl

Instruction-fetch sequencer between the 128×16 instruction RAM and the decode stage of the 16-bit heart-rate-monitor core. Owns the byte-addressed program counter, drives the IRAM `ADDR`, registers the returned word into a one-entry instruction buffer, and presents it to decode with a valid/ready handshake. It detects the HALT word, parks until a resume pulse, and accepts PC redirects from the branch unit.

## Interface
- `RESET_PC`: default 8'h00. PC loaded on reset; bit 0 must be 0.
- `HALT_WORD`: default 16'h0001. Encoding that halts fetch.
- `CLK`: in, 1. Clock.
- `RESET`: in, 1. Synchronous, active-high. Sampled on the same edge that loads the IRAM program.
- `ADDR`: out, 8. Byte address to IRAM (PC); IRAM uses `ADDR[7:1]`.
- `Q`: in, 16. IRAM read data, combinational from `ADDR`.
- `instr`: out, 16. Buffered instruction to decode.
- `instr_pc`: out, 8. Byte address of `instr`.
- `instr_valid`: out, 1. `instr` and `instr_pc` are valid.
- `instr_ready`: in, 1. Decode accepts `instr` this cycle.
- `redirect_valid`: in, 1. One-cycle request to change the PC.
- `redirect_addr`: in, 8. New byte PC. Bit 0 is forced to 0.
- `resume`: in, 1. One-cycle pulse that leaves HALT.
- `halted`: out, 1. High while in HALT.
- `issue_count`: out, 16. Count of accepted instructions (`instr_valid & instr_ready`). Wraps 16'hFFFF→0.

## Operation
- States: RUN and HALT. Reset enters RUN.
- Reset values:
  - `ADDR=RESET_PC`, `instr=0`, `instr_pc=0`, `instr_valid=0`, `halted=0`, `issue_count=0`.
- Buffer is free when `!instr_valid | instr_ready`.
- RUN, buffer free, no redirect:
  - Capture `Q` at `ADDR`.
  - Set `ADDR <= ADDR+2`, modulo 256, so 8'hFE wraps to 8'h00.
  - If `Q != HALT_WORD`: `instr<=Q`, `instr_pc<=ADDR`, `instr_valid<=1`.
  - If `Q == HALT_WORD`: `instr_valid<=0`, go to HALT. HALT is never issued to decode. After the halt, PC points past the HALT word.
- RUN, buffer not free: hold `ADDR`, `instr`, `instr_pc` and `instr_valid` stable.
- HALT:
  - `halted=1`, `instr_valid=0`, `ADDR` held.
  - `resume` → RUN on the next edge; fetch restarts at the held `ADDR`.
  - `redirect_valid` is ignored in HALT.
- Redirect in RUN takes priority over fetch:
  - `ADDR <= redirect_addr & 8'hFE`.
  - `instr_valid <= 0` (flush); the word on `Q` that cycle is discarded.
  - If the flushed buffer was accepted in the same cycle, it still counts in `issue_count`.
- `resume` while in RUN is ignored.
- `issue_count` increments on every `instr_valid & instr_ready` cycle, in any state.
- `RESET` asserted mid-operation: all state returns to reset values on that edge, regardless of redirect, resume or handshake activity.

## Timing
- Fetch latency: `ADDR` is driven in cycle n and the instruction is valid in cycle n+1.
- First `instr_valid` is in the second cycle after `RESET` deasserts. The IRAM has already been loaded during reset.
- Throughput is one instruction per cycle while `instr_ready=1`.
- Redirect takes 1 bubble cycle: `redirect_valid` in cycle n, new `ADDR` in n+1, target instruction valid in n+2.
- HALT:
  - `halted` rises the cycle after the HALT word is on `Q`.
  - `resume` in cycle n → RUN in n+1 → instruction valid in n+2.
- All outputs are registered except that `ADDR` is the PC register itself, so it is also registered.

## Structure
- Shared package `hrm_core_pkg` holds:
  - The state enum (RUN, HALT).
  - `HALT_WORD`.
  - Opcode field constants: `[15:12]`; ADD/SUB=4'b1111, ADDI=4'b0101, SB=4'b0100.
  - Instruction and address width constants (16, 8).
- No sub-module. The counter, PC and buffer are small enough to sit inline.

## Test plan
- Reset, then default program with `instr_ready=1`:
  - Issues PCs 0x00–0x0E in order (8 instructions).
  - `halted=1` with `ADDR=0x12` and `issue_count=8`.
  - `instr_valid` never shows 16'h0001.
- Pulse `resume` from that halt:
  - Issues 0x12, 0x14, 0x16, 0x18, 0x1A, then halts with `ADDR=0x1E` and `issue_count=13`.
- Backpressure: hold `instr_ready=0` for 3 cycles while `instr_pc=0x04`.
  - `instr`, `instr_pc` and `ADDR=0x06` stay stable.
  - Count unchanged; next accepted PC is 0x04, then 0x06.
- Redirect: assert `redirect_valid` with `redirect_addr=0x25` while `instr_pc=0x02` and ready=1.
  - Next cycle `ADDR=0x24` and `instr_valid=0`.
  - Following cycle `instr_pc=0x24`; `issue_count` includes the 0x02 instruction.
- Wrap: redirect to 0xFE. Issues PC 0xFE (word 0x0000), then 0x00, then 0x02.
- Corner cases:
  - `RESET` asserted in the same cycle as `redirect_valid` → `ADDR=0x00`, `instr_valid=0`, `issue_count=0`.
  - `redirect_valid` during HALT → ignored, `halted` stays 1, `ADDR` unchanged.
